// File: rtl/set_control_n.sv
// Per-field set-button controller: one accepted press gives a one-cycle increment strobe to the
// clock or alarm counter of its field. Optional auto-repeat while held: define SET_AUTOREPEAT_EN.
module set_control_n #(
  parameter int NFIELDS      = 2,
  parameter int DLY_W        = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic               ck,
  input  logic               reset,
  input  logic [NFIELDS-1:0] btn,
  input  logic               clock_alarm,
  input  logic [NFIELDS-1:0] carry_in,
  output logic [NFIELDS-1:0] up_clock,
  output logic [NFIELDS-1:0] up_alarm,
  output logic               busy
);

  localparam int OW = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;

  if (NFIELDS < 1 || DLY_W < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("set_control_n: NFIELDS, DLY_W, REPEAT_DELAY and REPEAT_RATE must all be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    HOLD     = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            mode_q,  mode_d;
  logic [OW-1:0]   low_idx;
  logic            owner_held;

  // Lowest pressed index wins a simultaneous press.
  always_comb begin
    low_idx = '0;
    for (int i = NFIELDS - 1; i >= 0; i--) begin
      if (btn[i]) low_idx = OW'(i);
    end
  end

  assign owner_held = btn[owner_q];

`ifdef SET_AUTOREPEAT_EN
  localparam logic [DLY_W-1:0] RPT_AT = DLY_W'(REPEAT_DELAY - 1);
  // A rate longer than the delay would reload below zero; clamp so the timer never wraps.
  localparam logic [DLY_W-1:0] RELOAD =
    (REPEAT_RATE <= REPEAT_DELAY) ? DLY_W'(REPEAT_DELAY - REPEAT_RATE) : '0;

  logic [DLY_W-1:0] timer_q, timer_d, timer_inc;

  assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
`endif

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mode_d  = mode_q;
`ifdef SET_AUTOREPEAT_EN
    timer_d = timer_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|btn) begin
          state_d = PULSE;
          owner_d = low_idx;
          mode_d  = clock_alarm;
`ifdef SET_AUTOREPEAT_EN
          timer_d = '0;
`endif
        end
      end
      PULSE: begin
        state_d = HOLD;
`ifdef SET_AUTOREPEAT_EN
        timer_d = timer_inc;
`endif
      end
      HOLD: begin
        if (!owner_held) begin
          state_d = WAIT_REL;
        end
`ifdef SET_AUTOREPEAT_EN
        else if (timer_q >= RPT_AT) begin
          state_d = PULSE;
          timer_d = RELOAD;
        end else begin
          timer_d = timer_inc;
        end
`endif
      end
      WAIT_REL: begin
        if (!(|btn)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      mode_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      mode_q  <= mode_d;
    end
  end

`ifdef SET_AUTOREPEAT_EN
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`endif

  logic               set_pulse;
  logic [NFIELDS-1:0] owner_onehot;

  assign set_pulse    = (state_q == PULSE);
  assign owner_onehot = NFIELDS'(1) << owner_q;

  // Carries merge with the set strobe rather than being displaced by it.
  assign up_clock = carry_in | ({NFIELDS{set_pulse &  mode_q}} & owner_onehot);
  assign up_alarm =            ({NFIELDS{set_pulse & ~mode_q}} & owner_onehot);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_set_control_n.sv
// Self-checking bench for set_control_n: directed scenarios then random presses, compared every
// cycle with an age-based reference model of the press/strobe rules.
module tb_set_control_n;

  localparam int NF = 2;
  localparam int D  = 5;
  localparam int R  = 3;

  logic          ck = 1'b0;
  logic          reset;
  logic [NF-1:0] btn;
  logic          clock_alarm;
  logic [NF-1:0] carry_in;
  logic [NF-1:0] up_clock;
  logic [NF-1:0] up_alarm;
  logic          busy;

  int checks = 0;
  int errors = 0;

  set_control_n #(
    .NFIELDS      (NF),
    .DLY_W        (8),
    .REPEAT_DELAY (D),
    .REPEAT_RATE  (R)
  ) dut (
    .ck          (ck),
    .reset       (reset),
    .btn         (btn),
    .clock_alarm (clock_alarm),
    .carry_in    (carry_in),
    .up_clock    (up_clock),
    .up_alarm    (up_alarm),
    .busy        (busy)
  );

  always #5 ck = ~ck;

  // Reference model: a press is tracked by its age (1 = the cycle right after acceptance).
  bit m_active   = 1'b0;
  bit m_released = 1'b0;
  int m_age      = 0;
  int m_owner    = 0;
  bit m_mode     = 1'b1;

  int obs_c[NF];
  int obs_a[NF];

  function automatic bit pulse_age(input int a);
`ifdef SET_AUTOREPEAT_EN
    return (a == 1) || (a > D && ((a - 1 - D) % R) == 0);
`else
    return (a == 1);
`endif
  endfunction

  task automatic clear_obs();
    for (int i = 0; i < NF; i++) begin
      obs_c[i] = 0;
      obs_a[i] = 0;
    end
  endtask

  task automatic check_val(input string tag, input logic [NF-1:0] obs, input logic [NF-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a falling edge: drive inputs, check this cycle, advance model, next negedge.
  task automatic cycle(input logic [NF-1:0] b, input logic ca, input logic [NF-1:0] cin,
                       input logic rn);
    bit            sp;
    logic [NF-1:0] exp_c, exp_a, onehot;
    btn         = b;
    clock_alarm = ca;
    carry_in    = cin;
    reset       = rn;
    if (!rn) begin
      m_active   = 1'b0;
      m_released = 1'b0;
    end
    #1;
    sp     = m_active && !m_released && pulse_age(m_age);
    onehot = '0;
    onehot[m_owner] = 1'b1;
    exp_c  = cin | ((sp && m_mode)  ? onehot : '0);
    exp_a  =       ((sp && !m_mode) ? onehot : '0);
    check_val("up_clock", up_clock, exp_c);
    check_val("up_alarm", up_alarm, exp_a);
    check_val("busy", NF'(busy), NF'(m_active));
    for (int i = 0; i < NF; i++) begin
      if (up_clock[i] && !cin[i]) obs_c[i]++;
      if (up_alarm[i])            obs_a[i]++;
    end
    if (rn) begin
      if (!m_active) begin
        if (b != '0) begin
          m_active   = 1'b1;
          m_released = 1'b0;
          m_age      = 1;
          m_mode     = ca;
          for (int i = NF - 1; i >= 0; i--) if (b[i]) m_owner = i;
        end
      end else if (m_released) begin
        if (b == '0) m_active = 1'b0;
      end else begin
        if (!pulse_age(m_age) && !b[m_owner]) m_released = 1'b1;
        m_age++;
      end
    end
    @(negedge ck);
  endtask

  logic [NF-1:0] rb;

  initial begin
    btn = '0; clock_alarm = 1'b1; carry_in = '0; reset = 1'b0;
    clear_obs();
    @(negedge ck);

    // T1: buttons held through reset; carry passes through; one pulse after release.
    repeat (3) cycle(2'b11, 1'b1, 2'b01, 1'b0);
    clear_obs();
    repeat (4) cycle(2'b11, 1'b1, 2'b00, 1'b1);
    repeat (3) cycle(2'b00, 1'b1, 2'b00, 1'b1);
    check_int("t1_clk0", obs_c[0], 1);
    check_int("t1_clk1", obs_c[1], 0);
    check_int("t1_alm",  obs_a[0] + obs_a[1], 0);

    // T2: single press on field 1, clock then alarm.
    clear_obs();
    repeat (4) cycle(2'b10, 1'b1, 2'b00, 1'b1);
    repeat (3) cycle(2'b00, 1'b1, 2'b00, 1'b1);
    check_int("t2_clk1", obs_c[1], 1);
    repeat (4) cycle(2'b10, 1'b0, 2'b00, 1'b1);
    repeat (3) cycle(2'b00, 1'b0, 2'b00, 1'b1);
    check_int("t2_alm1", obs_a[1], 1);
    check_int("t2_clk1_after", obs_c[1], 1);

    // T3: mode flips mid-press; latched mode holds.
    clear_obs();
    repeat (3) cycle(2'b01, 1'b0, 2'b00, 1'b1);
    repeat (2) cycle(2'b01, 1'b1, 2'b00, 1'b1);
    repeat (3) cycle(2'b00, 1'b1, 2'b00, 1'b1);
    check_int("t3_alm0", obs_a[0], 1);
    check_int("t3_clk",  obs_c[0] + obs_c[1], 0);

    // T4: carry merges with the set pulse; carries pass through while holding.
    cycle(2'b10, 1'b1, 2'b00, 1'b1);
    cycle(2'b10, 1'b1, 2'b10, 1'b1);
    check_val("t4_merge", up_clock, 2'b10);
    cycle(2'b10, 1'b1, 2'b01, 1'b1);
    cycle(2'b10, 1'b1, 2'b00, 1'b1);
    cycle(2'b10, 1'b1, 2'b01, 1'b1);
    repeat (3) cycle(2'b00, 1'b1, 2'b00, 1'b1);

    // T5: contention; field 1 ignored until all released and pressed again.
    clear_obs();
    repeat (2) cycle(2'b11, 1'b1, 2'b00, 1'b1);
    repeat (3) cycle(2'b10, 1'b1, 2'b00, 1'b1);
    check_int("t5_clk0", obs_c[0], 1);
    check_int("t5_clk1_held", obs_c[1], 0);
    repeat (2) cycle(2'b00, 1'b1, 2'b00, 1'b1);
    repeat (2) cycle(2'b10, 1'b1, 2'b00, 1'b1);
    repeat (3) cycle(2'b00, 1'b1, 2'b00, 1'b1);
    check_int("t5_clk1_repress", obs_c[1], 1);

    // T6: long hold on field 0.
    clear_obs();
    repeat (20) cycle(2'b01, 1'b1, 2'b00, 1'b1);
    repeat (3) cycle(2'b00, 1'b1, 2'b00, 1'b1);
`ifdef SET_AUTOREPEAT_EN
    check_int("t6_repeat", obs_c[0], 6);
`else
    check_int("t6_single", obs_c[0], 1);
`endif

    // Random presses with sticky buttons, sparse carries and one mid-run reset.
    rb = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) rb = NF'($urandom_range(3));
      cycle(rb, 1'($urandom_range(1)),
            ($urandom_range(9) == 0) ? NF'($urandom_range(3)) : '0,
            !(i >= 300 && i < 302));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
